// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use stalls, branch/jump flushes,
// and a halt sequence that freezes the front end while MEM and WB drain.
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_RegWrite,
  input  logic        ex_MemtoReg,
  input  logic [4:0]  ex_WbRegNum,
  input  logic        ex_redirect,
  input  logic        ex_halt,
  input  logic        go,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        ifid_clr,
  output logic        bb_data,
  output logic        bb_bj,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_drain_cnt;
  logic       w_load_use;

  // Writes to $0 are discarded, so a load targeting $0 never creates a hazard.
  assign w_load_use = ex_RegWrite && ex_MemtoReg && (ex_WbRegNum != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_WbRegNum)) ||
                       (id_uses_rt && (id_rt == ex_WbRegNum)));

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    w_state_nxt = r_state;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    ifid_clr    = 1'b0;
    bb_data     = 1'b0;
    bb_bj       = 1'b0;
    halted      = 1'b0;
    unique case (r_state)
      RUN: begin
        // Redirect wins: the dependent instruction in ID is squashed anyway.
        if (ex_redirect) begin
          pc_en    = 1'b1;
          ifid_clr = 1'b1;
          bb_bj    = 1'b1;
        end else if (w_load_use) begin
          bb_data  = 1'b1;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
        end
        if (ex_halt) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (r_drain_cnt == 2'd0) w_state_nxt = HALT;
      end
      HALT: begin
        halted = 1'b1;
        if (go) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
    // Reset forces state to RUN, so outputs are gated to hold everything quiet during reset.
    if (!rst_n) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      ifid_clr = 1'b0;
      bb_data  = 1'b0;
      bb_bj    = 1'b0;
      halted   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_drain_cnt <= 2'd0;
      stall_cnt   <= 16'd0;
      flush_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == RUN && ex_halt)
        r_drain_cnt <= 2'd2;
      else if (r_state == DRAIN && r_drain_cnt != 2'd0)
        r_drain_cnt <= r_drain_cnt - 2'd1;
      if (bb_data && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 16'd1;
      if (bb_bj   && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: reset, load-use, redirect priority,
// halt/drain/resume, counter saturation and reset out of HALT.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_WbRegNum;
  logic        id_uses_rs, id_uses_rt, ex_RegWrite, ex_MemtoReg;
  logic        ex_redirect, ex_halt, go;
  logic        pc_en, ifid_en, idex_en, ifid_clr, bb_data, bb_bj, halted;
  logic [15:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Output vector order: {pc_en, ifid_en, idex_en, ifid_clr, bb_data, bb_bj, halted}
  localparam logic [6:0] O_RUN  = 7'b1110000;
  localparam logic [6:0] O_BJ   = 7'b1001010;
  localparam logic [6:0] O_LU   = 7'b0000100;
  localparam logic [6:0] O_FRZ  = 7'b0000000;
  localparam logic [6:0] O_HALT = 7'b0000001;

  logic [6:0] outs;
  assign outs = {pc_en, ifid_en, idex_en, ifid_clr, bb_data, bb_bj, halted};

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg), .ex_WbRegNum(ex_WbRegNum),
    .ex_redirect(ex_redirect), .ex_halt(ex_halt), .go(go),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .ifid_clr(ifid_clr),
    .bb_data(bb_data), .bb_bj(bb_bj), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                       input logic urt, input logic rw, input logic m2r,
                       input logic [4:0] wb, input logic redir, input logic hlt,
                       input logic g);
    id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    ex_RegWrite = rw; ex_MemtoReg = m2r; ex_WbRegNum = wb;
    ex_redirect = redir; ex_halt = hlt; go = g;
  endtask

  task automatic idle();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #2;
    n_vec++;
    if (outs !== O_FRZ) begin
      n_err++; $display("FAIL reset_outs: got %b want %b", outs, O_FRZ);
    end
    n_vec++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_cnts: got %h/%h want 0000/0000", stall_cnt, flush_cnt);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_vec++;
    if (outs !== O_RUN) begin
      n_err++; $display("FAIL post_reset_run: got %b want %b", outs, O_RUN);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    drive(5'd8, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0); #1;
    n_vec++;
    if (outs !== O_LU) begin
      n_err++; $display("FAIL lu_rs_outs: got %b want %b", outs, O_LU);
    end
    @(negedge clk);
    n_vec++;
    if (stall_cnt !== 16'd1) begin
      n_err++; $display("FAIL lu_rs_cnt: got %0d want 1", stall_cnt);
    end
    drive(5'd0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    n_vec++;
    if (outs !== O_RUN) begin
      n_err++; $display("FAIL lu_zero_reg: got %b want %b", outs, O_RUN);
    end
    @(negedge clk);
    n_vec++;
    if (stall_cnt !== 16'd1) begin
      n_err++; $display("FAIL lu_zero_cnt: got %0d want 1", stall_cnt);
    end
    drive(5'd8, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0); #1;
    n_vec++;
    if (outs !== O_RUN) begin
      n_err++; $display("FAIL lu_rs_unused: got %b want %b", outs, O_RUN);
    end
    @(negedge clk);
    drive(5'd1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0); #1;
    n_vec++;
    if (outs !== O_LU) begin
      n_err++; $display("FAIL lu_rt_outs: got %b want %b", outs, O_LU);
    end
    @(negedge clk);
    drive(5'd8, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0); #1;
    n_vec++;
    if (outs !== O_RUN) begin
      n_err++; $display("FAIL non_load_dep: got %b want %b", outs, O_RUN);
    end
    n_vec++;
    if (stall_cnt !== 16'd2) begin
      n_err++; $display("FAIL lu_rt_cnt: got %0d want 2", stall_cnt);
    end
  endtask

  task automatic test_redirect_priority();
    @(negedge clk);
    drive(5'd8, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0); #1;
    n_vec++;
    if (outs !== O_BJ) begin
      n_err++; $display("FAIL redir_lu_outs: got %b want %b", outs, O_BJ);
    end
    @(negedge clk);
    idle(); #1;
    n_vec++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd2) begin
      n_err++; $display("FAIL redir_lu_cnts: got flush %0d stall %0d want 1 2", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_halt_sequence();
    @(negedge clk);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); #1;
    n_vec++;
    if (outs !== O_RUN) begin
      n_err++; $display("FAIL halt_cycle_run: got %b want %b", outs, O_RUN);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      // go, ex_halt and a redirect during DRAIN must all be ignored.
      drive(5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, (i == 1), 1'b1, 1'b1); #1;
      n_vec++;
      if (outs !== O_FRZ) begin
        n_err++; $display("FAIL drain_%0d: got %b want %b", i, outs, O_FRZ);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, (i == 1)); #1;
      n_vec++;
      if (outs !== O_HALT) begin
        n_err++; $display("FAIL halt_%0d: got %b want %b", i, outs, O_HALT);
      end
    end
    n_vec++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd2) begin
      n_err++; $display("FAIL drain_cnts_hold: got flush %0d stall %0d want 1 2", flush_cnt, stall_cnt);
    end
    @(negedge clk);
    idle(); #1;
    n_vec++;
    if (outs !== O_RUN) begin
      n_err++; $display("FAIL resume_run: got %b want %b", outs, O_RUN);
    end
    @(negedge clk); #1;
    n_vec++;
    if (outs !== O_RUN) begin
      n_err++; $display("FAIL resume_stays_run: got %b want %b", outs, O_RUN);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    rst_n = 1'b0; #1; rst_n = 1'b1;
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    repeat (65534) @(posedge clk);
    @(negedge clk); #1;
    n_vec++;
    if (flush_cnt !== 16'hFFFE) begin
      n_err++; $display("FAIL sat_preload: got %h want fffe", flush_cnt);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    idle(); #1;
    n_vec++;
    if (flush_cnt !== 16'hFFFF) begin
      n_err++; $display("FAIL sat_flush: got %h want ffff", flush_cnt);
    end
  endtask

  task automatic test_reset_in_halt();
    @(negedge clk);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (outs !== O_HALT) begin
      n_err++; $display("FAIL rih_parked: got %b want %b", outs, O_HALT);
    end
    #1; rst_n = 1'b0; #1;
    n_vec++;
    if (outs !== O_FRZ) begin
      n_err++; $display("FAIL rih_async: got %b want %b", outs, O_FRZ);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_vec++;
    if (outs !== O_RUN) begin
      n_err++; $display("FAIL rih_release: got %b want %b", outs, O_RUN);
    end
    n_vec++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_err++; $display("FAIL rih_cnts: got %h/%h want 0000/0000", stall_cnt, flush_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect_priority();
    test_halt_sequence();
    test_saturation();
    test_reset_in_halt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single pipeline clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have ports id_rs and id_rt, input, 5 bits each: source register numbers of the instruction in ID.
REQ-004 The block SHALL have ports id_uses_rs and id_uses_rt, input, 1 bit each: the ID instruction reads rs / reads rt.
REQ-005 The block SHALL have ports ex_RegWrite and ex_MemtoReg, input, 1 bit each: the EX instruction writes a register / is a load.
REQ-006 The block SHALL have port ex_WbRegNum, input, 5 bits: destination register number of the EX instruction.
REQ-007 The block SHALL have port ex_redirect, input, 1 bit: a taken branch or jump was resolved in EX this cycle.
REQ-008 The block SHALL have port ex_halt, input, 1 bit: a halting SYSCALL is in EX this cycle.
REQ-009 The block SHALL have port go, input, 1 bit: resume pulse from the host.
REQ-010 The block SHALL have outputs pc_en, ifid_en and idex_en, 1 bit each: write enables for PC, IF/ID and ID/EX.
REQ-011 The block SHALL have output ifid_clr, 1 bit: synchronous clear of IF/ID.
REQ-012 The block SHALL have outputs bb_data and bb_bj, 1 bit each: ID/EX bubble requests for a data hazard / a branch-jump flush.
REQ-013 The block SHALL have output halted, 1 bit: the core is parked.
REQ-014 The block SHALL have outputs stall_cnt and flush_cnt, 16 bits each: event counters.

Function
REQ-015 The state machine SHALL have exactly three states: RUN, DRAIN and HALT.
REQ-016 load_use SHALL be defined as ex_RegWrite & ex_MemtoReg & (ex_WbRegNum != 0) & ((id_uses_rs & id_rs == ex_WbRegNum) | (id_uses_rt & id_rt == ex_WbRegNum)).
REQ-017 In RUN with no event, the outputs SHALL be pc_en = ifid_en = idex_en = 1, with all other control outputs at 0.
REQ-018 In RUN with ex_redirect = 1, the outputs SHALL be pc_en = 1, ifid_en = 0, ifid_clr = 1, idex_en = 0 and bb_bj = 1, with bb_data = 0.
REQ-019 In RUN with load_use = 1 and ex_redirect = 0, the outputs SHALL be pc_en = ifid_en = idex_en = 0 and bb_data = 1, with ifid_clr = 0 and bb_bj = 0.
REQ-020 ex_redirect SHALL take priority over load_use, because the dependent instruction is being squashed.
REQ-021 bb_data and bb_bj SHALL never be asserted in the same cycle.
REQ-022 All outputs SHALL be combinational from the current state and the current inputs, giving zero-cycle latency.
REQ-023 RUN SHALL go to DRAIN on a clock edge where ex_halt = 1; the outputs in that cycle SHALL follow REQ-017 to REQ-019.
REQ-024 DRAIN SHALL hold a 2-bit down-counter that loads 2 on entry, and SHALL go to HALT on the edge where the counter is 0 (three cycles spent in DRAIN).
REQ-025 In DRAIN and HALT, all enables, clears and bubbles SHALL be 0, freezing IF, ID and EX while MEM and WB drain.
REQ-026 halted SHALL be 1 only in HALT.
REQ-027 HALT SHALL go to RUN on the edge where go = 1; go SHALL be ignored in RUN and DRAIN.
REQ-028 ex_halt SHALL be ignored in DRAIN and HALT.
REQ-029 stall_cnt SHALL increment once per RUN cycle that asserts bb_data.
REQ-030 flush_cnt SHALL increment once per RUN cycle that asserts bb_bj.
REQ-031 Both counters SHALL saturate at 16'hFFFF with no wrap, and SHALL hold their values through DRAIN and HALT.

Reset
REQ-032 When rst_n = 0, the block SHALL immediately and without waiting for clk enter RUN, clear the DRAIN counter, and clear stall_cnt and flush_cnt to 0.
REQ-033 While rst_n = 0, the outputs SHALL be pc_en = ifid_en = idex_en = 0, ifid_clr = bb_data = bb_bj = 0 and halted = 0.
REQ-034 On release of rst_n, the block SHALL behave per REQ-017.
REQ-035 Reset asserted during DRAIN or HALT SHALL abort the halt without requiring go.

Verification
REQ-036 The bench SHALL cover the load-use case: ex_RegWrite = 1, ex_MemtoReg = 1, ex_WbRegNum = 8, id_rs = 8, id_uses_rs = 1 -> bb_data = 1, all enables 0, stall_cnt goes 0 -> 1 after the edge.
REQ-037 The bench SHALL cover load-use to $0: the same stimulus with ex_WbRegNum = 0 and id_rs = 0 -> no stall and stall_cnt unchanged; the same stimulus with id_uses_rs = 0 -> no stall.
REQ-038 The bench SHALL cover a redirect concurrent with load-use: ex_redirect = 1 with the REQ-036 stimulus -> bb_bj = 1, ifid_clr = 1, pc_en = 1, bb_data = 0, flush_cnt +1, stall_cnt unchanged.
REQ-039 The bench SHALL cover the halt sequence: ex_halt pulsed for one cycle in RUN -> enables 0 for 3 cycles with halted = 0, then halted = 1; go during DRAIN is ignored; go in HALT -> RUN and enables 1 on the next cycle.
REQ-040 The bench SHALL cover counter saturation: flush_cnt preloaded to 16'hFFFE by forcing ex_redirect for 65534 cycles, then 3 further redirect cycles -> flush_cnt = 16'hFFFF.
REQ-041 The bench SHALL cover reset in HALT: rst_n driven low mid-HALT -> halted = 0 with no clock edge; after release, the outputs match REQ-017 and both counters are 0.
